// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, instruction-memory fetch handshake and command register for the decoder
// Optional macro IFETCH_HALT_EN adds a HALT state entered when a HALT-encoded command is consumed.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  output logic [15:0] command,
  output logic        cmd_valid,
  input  logic        cmd_ack,
  input  logic        pc_load,
  input  logic [15:0] pc_target,
  output logic [15:0] pc_cur,
  output logic        halted
);

`ifdef IFETCH_HALT_EN
  typedef enum logic [1:0] {ST_FETCH, ST_FULL, ST_HALT} state_t;
`else
  typedef enum logic [1:0] {ST_FETCH, ST_FULL} state_t;
`endif

  state_t      state, state_nxt;
  logic [15:0] pc;
  logic        fetch_done;
  logic        consume;

  assign fetch_done = (state == ST_FETCH) && imem_ack;
  assign consume    = (state == ST_FULL) && cmd_ack;

  // Request is decoded from state so it is live the first cycle after reset releases.
  assign imem_req  = (state == ST_FETCH) && !rst;
  assign imem_addr = pc;
  assign cmd_valid = (state == ST_FULL);

`ifdef IFETCH_HALT_EN
  logic is_halt;
  assign is_halt = (command[15:14] == 2'b11) && (command[7:4] == 4'b1111);
  assign halted  = (state == ST_HALT);
`else
  assign halted  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: if (imem_ack) state_nxt = ST_FULL;
      ST_FULL: begin
        if (cmd_ack) begin
`ifdef IFETCH_HALT_EN
          state_nxt = is_halt ? ST_HALT : ST_FETCH;
`else
          state_nxt = ST_FETCH;
`endif
        end
      end
      default: state_nxt = state;
    endcase
  end

  // pc already points past the held word, so a non-branch consume leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      command <= 16'h0000;
      pc_cur  <= 16'h0000;
    end else if (fetch_done) begin
      command <= imem_rdata;
      pc_cur  <= pc;
      pc      <= pc + 16'd1;
    end else if (consume && pc_load) begin
      pc      <= pc_target;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed bench with per-cycle reference model for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_rdata;
  logic [15:0] command, pc_cur, pc_target;
  logic        cmd_valid, cmd_ack, pc_load, halted;

  logic        imem_req2, imem_ack2, cmd_valid2, halted2;
  logic [15:0] imem_addr2, imem_rdata2, command2, pc_cur2;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_wait = 0;
  int wcnt     = 0;
  bit halt_mode = 0;
  bit done = 0;

  instr_fetch_unit #(.RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .command(command),
    .cmd_valid(cmd_valid), .cmd_ack(cmd_ack), .pc_load(pc_load),
    .pc_target(pc_target), .pc_cur(pc_cur), .halted(halted)
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFF)) u_dut2 (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .imem_ack(imem_ack2), .command(command2),
    .cmd_valid(cmd_valid2), .cmd_ack(cmd_ack), .pc_load(pc_load),
    .pc_target(pc_target), .pc_cur(pc_cur2), .halted(halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_mode && a == 16'h0005) return 16'hC0F0;
    return a ^ 16'hA5A5;
  endfunction

  // Memory responders: dut1 with programmable wait states, dut2 zero-wait.
  initial begin
    imem_ack = 0; imem_rdata = 0; imem_ack2 = 0; imem_rdata2 = 0;
    forever begin
      @(negedge clk);
      if (imem_req && !rst) begin
        if (wcnt >= mem_wait) begin
          imem_ack = 1; imem_rdata = mem_word(imem_addr); wcnt = 0;
        end else begin
          imem_ack = 0; wcnt++;
        end
      end else begin
        imem_ack = 0; wcnt = 0;
      end
      imem_ack2   = imem_req2 && !rst;
      imem_rdata2 = imem_addr2 ^ 16'hA5A5;
    end
  end

  // Reference model: one word buffer between memory and decoder.
  logic [15:0] m_pc, m_cmd, m_cur;
  bit          m_have, m_halt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 16'h0000; m_cmd = 16'h0000; m_cur = 16'h0000; m_have = 0; m_halt = 0;
    end else if (!m_halt) begin
      if (!m_have) begin
        if (imem_ack) begin
          m_cmd = imem_rdata; m_cur = m_pc; m_pc = m_pc + 16'd1; m_have = 1;
        end
      end else if (cmd_ack) begin
        m_have = 0;
        if (pc_load) m_pc = pc_target;
`ifdef IFETCH_HALT_EN
        if (m_cmd[15:14] == 2'b11 && m_cmd[7:4] == 4'hF) m_halt = 1;
`endif
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk); #1;
      if (!done) begin
        chk("model_req", {15'd0, imem_req}, {15'd0, !rst && !m_have && !m_halt});
        chk("model_addr", imem_addr, m_pc);
        chk("model_valid", {15'd0, cmd_valid}, {15'd0, m_have});
        chk("model_command", command, m_cmd);
        chk("model_pc_cur", pc_cur, m_cur);
        chk("model_halted", {15'd0, halted}, {15'd0, m_halt});
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_cur(input logic [15:0] target, input string name);
    bit found = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cmd_valid && pc_cur == target) begin
        found = 1;
        break;
      end
    end
    chk(name, {15'd0, found}, 16'd1);
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick();
    rst = 0;
  endtask

  initial begin
    rst = 1; cmd_ack = 0; pc_load = 0; pc_target = 0;
    tick(); tick();
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_valid", {15'd0, cmd_valid}, 16'd0);
    chk("rst_command", command, 16'h0000);
    chk("rst_pc_cur", pc_cur, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_addr2", imem_addr2, 16'hFFFF);

    // Zero-wait streaming, cmd_ack tied high.
    rst = 0; cmd_ack = 1;
    tick();
    chk("first_req", {15'd0, imem_req}, 16'd1);
    chk("first_addr", imem_addr, 16'h0000);
    wait_cur(16'h0000, "stream_start");
    for (int k = 0; k < 4; k++) begin
      chk("stream_command", command, 16'(k) ^ 16'hA5A5);
      chk("stream_pc_cur", pc_cur, 16'(k));
      chk("wrap_pc_cur", pc_cur2, 16'hFFFF + 16'(k));
      chk("wrap_command", command2, (16'hFFFF + 16'(k)) ^ 16'hA5A5);
      tick();
      chk("stream_req", {15'd0, imem_req}, 16'd1);
      chk("stream_addr", imem_addr, 16'(k + 1));
      chk("wrap_addr", imem_addr2, 16'hFFFF + 16'(k + 1));
      tick();
      chk("stream_valid", {15'd0, cmd_valid}, 16'd1);
    end

    // Memory ack delayed three cycles.
    cmd_ack = 0; mem_wait = 3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_req", {15'd0, imem_req}, 16'd1);
      chk("wait_addr", imem_addr, 16'h0000);
      chk("wait_valid", {15'd0, cmd_valid}, 16'd0);
    end
    tick();
    chk("wait_valid_rise", {15'd0, cmd_valid}, 16'd1);
    chk("wait_command", command, 16'hA5A5);

    // Downstream stall with a stray pc_load.
    pc_load = 1; pc_target = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {15'd0, cmd_valid}, 16'd1);
      chk("stall_command", command, 16'hA5A5);
      chk("stall_pc_cur", pc_cur, 16'h0000);
      chk("stall_req", {15'd0, imem_req}, 16'd0);
    end
    pc_load = 0; cmd_ack = 1; mem_wait = 0;
    tick();
    chk("stall_next_addr", imem_addr, 16'h0001);

    // Branch taken at pc_cur 0x0010.
    wait_cur(16'h0010, "branch_reach");
    pc_load = 1; pc_target = 16'h0200;
    tick();
    pc_load = 0;
    chk("branch_req", {15'd0, imem_req}, 16'd1);
    chk("branch_addr", imem_addr, 16'h0200);
    tick();
    chk("branch_pc_cur", pc_cur, 16'h0200);
    chk("branch_command", command, 16'hA7A5);

    // HALT-encoded word at address 5.
    halt_mode = 1;
    do_reset();
    wait_cur(16'h0005, "halt_reach");
    chk("halt_word", command, 16'hC0F0);
    tick();
`ifdef IFETCH_HALT_EN
    for (int i = 0; i < 3; i++) begin
      chk("halt_halted", {15'd0, halted}, 16'd1);
      chk("halt_req", {15'd0, imem_req}, 16'd0);
      chk("halt_valid", {15'd0, cmd_valid}, 16'd0);
      tick();
    end
    rst = 1;
    tick();
    chk("halt_rst_halted", {15'd0, halted}, 16'd0);
    rst = 0;
    tick();
    chk("halt_restart_req", {15'd0, imem_req}, 16'd1);
    chk("halt_restart_addr", imem_addr, 16'h0000);
`else
    chk("nohalt_halted", {15'd0, halted}, 16'd0);
    chk("nohalt_req", {15'd0, imem_req}, 16'd1);
    chk("nohalt_addr", imem_addr, 16'h0006);
    tick();
    chk("nohalt_pc_cur", pc_cur, 16'h0006);
    chk("nohalt_command", command, 16'hA5A3);
`endif
    tick();
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage that sits directly upstream of the instruction decoder. Holds the program counter, fetches one 16-bit instruction word at a time from instruction memory over a request/acknowledge handshake, and presents it as `command` with a valid flag until the execute side consumes it. Branches are applied through a PC-load request that accompanies consumption of the current command.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock, all state rises on posedge.
- `rst`  in  1  reset; asynchronous, active-high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  16  word address of the fetch; equals `pc`.
- `imem_rdata`  in  16  instruction word; valid in the cycle `imem_ack`=1.
- `imem_ack`  in  1  memory completes the fetch this cycle; ignored when `imem_req`=0.
- `command`  out  16  instruction register, drives decoder `COMMAND`.
- `cmd_valid`  out  1  `command` holds a fetched, unconsumed instruction.
- `cmd_ack`  in  1  downstream consumes `command` this cycle; ignored when `cmd_valid`=0.
- `pc_load`  in  1  branch taken; sampled only with `cmd_valid && cmd_ack`.
- `pc_target`  in  16  branch destination; sampled with `pc_load`.
- `pc_cur`  out  16  address from which `command` was fetched.
- `halted`  out  1  fetch stopped by HALT (only with `IFETCH_HALT_EN`; tied 0 otherwise).

## Operation
- State machine: FETCH, FULL, HALT (HALT exists only with `IFETCH_HALT_EN`).
- Reset values: state FETCH, `pc`=`RESET_PC`, `command`=16'h0000, `cmd_valid`=0, `pc_cur`=16'h0000, `halted`=0. `imem_req` and `imem_addr` are decoded from state/`pc`, so `imem_req`=1 and `imem_addr`=`RESET_PC` immediately after reset deasserts; while `rst`=1, `imem_req` is forced to 0.
- FETCH: `imem_req`=1, `imem_addr`=`pc`, both held stable until `imem_ack`. On `imem_ack`: `command`<=`imem_rdata`, `pc_cur`<=`pc`, `pc`<=`pc`+1, `cmd_valid`<=1, next FULL.
- FULL: `imem_req`=0; `command`, `pc_cur` held. On `cmd_ack`: `cmd_valid`<=0; if `pc_load`=1 then `pc`<=`pc_target`, else `pc` unchanged (already incremented); next FETCH (or HALT, see Configuration).
- `pc_load` with `cmd_valid`=0 or `cmd_ack`=0: ignored, no state change.
- PC arithmetic: 16-bit word addressing, modulo 2^16; `pc`=16'hFFFF increments to 16'h0000, and `pc_cur` reports 16'hFFFF for that word.
- `imem_ack` in FULL or HALT: ignored; memory must not ack without a request.
- Reset mid-fetch or mid-hold: all state cleared asynchronously; any in-flight memory response after reset deasserts is accepted only as an ack of the new FETCH of `RESET_PC`.

## Timing
- Zero-wait memory (ack in the request cycle): request in cycle N, `cmd_valid`=1 in N+1.
- With `cmd_ack` asserted in the first valid cycle: next request in N+2; peak throughput one instruction per 2 cycles.
- Branch: `pc_target` appears on `imem_addr` in the cycle after `cmd_ack`&&`pc_load`; no wrong-path instruction is ever fetched.
- Each memory wait cycle adds exactly one cycle of latency; each downstream stall cycle holds FULL for one more cycle.

## Configuration
- `IFETCH_HALT_EN` defined: HALT encoding is `command[15:14]`=2'b11 and `command[7:4]`=4'b1111. When such a command is consumed (`cmd_ack` in FULL), next state HALT: `imem_req`=0, `cmd_valid`=0, `halted`=1; only `rst` leaves HALT. A `pc_load` sampled with the HALT consumption still updates `pc`.
- Not defined: no HALT state; that encoding is fetched and passed on like any other word; `halted` is constant 0.

## Test plan
- Reset, zero-wait memory returning `imem_rdata`=addr^16'hA5A5, `cmd_ack` tied 1 -> `imem_addr` sequence 0,1,2,3 on every other cycle; `command` 16'hA5A5, 16'hA5A4, …; `pc_cur` 0,1,2,3.
- Memory ack delayed 3 cycles -> `imem_req`/`imem_addr`=0 held stable for 4 cycles; `cmd_valid` rises the cycle after the ack.
- `cmd_ack` withheld 5 cycles with `cmd_valid`=1 -> `command` and `pc_cur` stable, `imem_req`=0 throughout; `pc_load`=1 during the wait is ignored.
- At `pc_cur`=16'h0010, `cmd_ack`=1 with `pc_load`=1 and `pc_target`=16'h0200 -> next `imem_addr`=16'h0200, next `pc_cur`=16'h0200.
- `RESET_PC`=16'hFFFF -> first fetch at 16'hFFFF, second at 16'h0000.
- With `IFETCH_HALT_EN`, word 16'hC0F0 fetched at address 5 and consumed -> `halted`=1, no further `imem_req`; assert `rst` mid-halt -> `halted`=0 and fetching restarts at `RESET_PC`. Without the macro, the same word is passed on and fetching continues at address 6.
